// File: rtl/sample_stream_source_pkg.sv
// sample_stream_pkg: shared types for the sample stream source slice.
//   DATA_W             - beat width in bits
//   stream_src_state_t - output FSM states (IDLE, SEND, GAP)
//   stream_byte_t      - one stream beat
package sample_stream_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } stream_src_state_t;

  typedef logic [DATA_W-1:0] stream_byte_t;

endpackage : sample_stream_pkg

// File: rtl/sample_stream_source_if.sv
// sample_stream_source_if: write-side and stream-side handshake signals of
// the sample stream source.
//   master - the source block: accepts writes, drives the output stream
//   slave  - the environment: issues writes, consumes the output stream
// Optional macro STREAM_SOURCE_PARITY_EN adds stream_out_parity.
interface sample_stream_source_if;
  import sample_stream_pkg::*;

  logic         wr_valid;
  logic         wr_ready;
  stream_byte_t wr_data;
  logic         stream_out_valid;
  logic         stream_out_ready;
  stream_byte_t stream_out_data;
`ifdef STREAM_SOURCE_PARITY_EN
  logic         stream_out_parity;

  modport master (
    input  wr_valid, wr_data, stream_out_ready,
    output wr_ready, stream_out_valid, stream_out_data, stream_out_parity
  );
  modport slave (
    output wr_valid, wr_data, stream_out_ready,
    input  wr_ready, stream_out_valid, stream_out_data, stream_out_parity
  );
`else
  modport master (
    input  wr_valid, wr_data, stream_out_ready,
    output wr_ready, stream_out_valid, stream_out_data
  );
  modport slave (
    output wr_valid, wr_data, stream_out_ready,
    input  wr_ready, stream_out_valid, stream_out_data
  );
`endif

endinterface : sample_stream_source_if

// File: rtl/sample_stream_source_fifo.sv
// sample_stream_fifo: DEPTH-entry byte FIFO (DEPTH a power of two, >= 2).
//   clk, reset_n - clock, asynchronous active-low reset (empties the FIFO)
//   push, wr_data - enqueue request; ignored while full
//   pop           - dequeue request; ignored while empty
//   head          - oldest entry (valid when not empty)
//   full, empty, level - occupancy
module sample_stream_fifo
  import sample_stream_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  stream_byte_t             wr_data,
  input  logic                     pop,
  output stream_byte_t             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  stream_byte_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   level_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers are AW bits wide, so they wrap modulo DEPTH on overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule : sample_stream_fifo

// File: rtl/sample_stream_source.sv
// sample_stream_source: byte-stream transmitter. Bytes written into an
// internal FIFO are sent one beat at a time on a ready/valid stream, with
// gap_cycles idle cycles inserted after each accepted beat.
//   clk, reset_n - clock, asynchronous active-low reset
//   sif          - write port (wr_*) and output stream (stream_out_*)
//   gap_cycles   - idle cycles after each beat, sampled at the handshake
//   fifo_level   - FIFO occupancy
//   beat_count   - completed output handshakes (wrapping)
//   busy         - FSM not idle or FIFO not empty
// Optional macro STREAM_SOURCE_PARITY_EN: drives sif.stream_out_parity with
// the even parity of the byte held in the output register.
module sample_stream_source
  import sample_stream_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned GAP_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  sample_stream_source_if.master sif,
  input  logic [GAP_W-1:0]       gap_cycles,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]       beat_count,
  output logic                   busy
);

  stream_src_state_t state_q;
  stream_byte_t      data_q;
  logic              valid_q;
  logic [GAP_W-1:0]  gap_cnt_q;
  logic [CNT_W-1:0]  beat_cnt_q;

  stream_byte_t      head;
  logic              full;
  logic              empty;
  logic              pop;
  logic              hs;

  sample_stream_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (sif.wr_valid),
    .wr_data (sif.wr_data),
    .pop     (pop),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  assign hs = valid_q && sif.stream_out_ready;

  // Pop decision feeds the FIFO in the same cycle the FSM moves to SEND.
  always_comb begin
    pop = 1'b0;
    unique case (state_q)
      IDLE:    pop = !empty;
      SEND:    pop = hs && (gap_cycles == '0) && !empty;
      GAP:     pop = (gap_cnt_q == GAP_W'(1)) && !empty;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      data_q     <= '0;
      valid_q    <= 1'b0;
      gap_cnt_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      if (pop) data_q <= head;
      if (hs)  beat_cnt_q <= beat_cnt_q + CNT_W'(1);
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            state_q <= SEND;
            valid_q <= 1'b1;
          end
        end
        SEND: begin
          if (hs) begin
            if (gap_cycles != '0) begin
              gap_cnt_q <= gap_cycles;
              state_q   <= GAP;
              valid_q   <= 1'b0;
            end else if (!pop) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
            end
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_W'(1)) begin
            state_q <= pop ? SEND : IDLE;
            valid_q <= pop;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef STREAM_SOURCE_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  parity_q <= 1'b0;
    else if (pop)  parity_q <= ^head;
  end

  assign sif.stream_out_parity = parity_q;
`endif

  assign sif.wr_ready         = !full;
  assign sif.stream_out_valid = valid_q;
  assign sif.stream_out_data  = data_q;
  assign beat_count           = beat_cnt_q;
  assign busy                 = (state_q != IDLE) || (fifo_level != '0);

endmodule : sample_stream_source

// File: tb/tb_sample_stream_source.sv
module tb_sample_stream_source;
  import sample_stream_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  gap_cycles;
  logic [2:0]  fifo_level;
  logic [15:0] beat_count;
  logic        busy;

  // Narrow-counter, minimum-depth instance for the wrap scenario.
  logic [3:0]  gap_w;
  logic [1:0]  level_w;
  logic [3:0]  beat_w;
  logic        busy_w;

  int checks   = 0;
  int failures = 0;

  sample_stream_source_if sif ();
  sample_stream_source_if sif_w ();

  sample_stream_source #(.DEPTH(4), .GAP_W(4), .CNT_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sif        (sif),
    .gap_cycles (gap_cycles),
    .fifo_level (fifo_level),
    .beat_count (beat_count),
    .busy       (busy)
  );

  sample_stream_source #(.DEPTH(2), .GAP_W(4), .CNT_W(4)) dut_w (
    .clk        (clk),
    .reset_n    (reset_n),
    .sif        (sif_w),
    .gap_cycles (gap_w),
    .fifo_level (level_w),
    .beat_count (beat_w),
    .busy       (busy_w)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic collect(input int max_cycles, output stream_byte_t got[8], output int n);
    n = 0;
    for (int c = 0; c < max_cycles; c++) begin
      if (sif.stream_out_valid && sif.stream_out_ready && n < 8) begin
        got[n] = sif.stream_out_data;
        n++;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    checks++; if (sif.wr_ready !== 1'b1) begin failures++; $display("FAIL rst_wr_ready got=%0b exp=1", sif.wr_ready); end
    checks++; if (sif.stream_out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", sif.stream_out_valid); end
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    checks++; if (sif.stream_out_valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%0b exp=0", sif.stream_out_valid); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL idle_level got=%0d exp=0", fifo_level); end
    checks++; if (sif.wr_ready !== 1'b1) begin failures++; $display("FAIL idle_wr_ready got=%0b exp=1", sif.wr_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%0b exp=0", busy); end
    checks++; if (beat_count !== 16'd0) begin failures++; $display("FAIL idle_beats got=%0d exp=0", beat_count); end
    checks++; if (sif.stream_out_data !== 8'h00) begin failures++; $display("FAIL idle_data got=%0h exp=0", sif.stream_out_data); end
  endtask

  task automatic test_latency();
    gap_cycles = 4'd0;
    sif.stream_out_ready = 1'b1;
    sif.wr_valid = 1'b1;
    sif.wr_data  = 8'hA5;
    tick();
    checks++; if (sif.stream_out_valid !== 1'b0) begin failures++; $display("FAIL lat_not_yet got=%0b exp=0", sif.stream_out_valid); end
    checks++; if (fifo_level !== 3'd1) begin failures++; $display("FAIL lat_level got=%0d exp=1", fifo_level); end
    sif.wr_data = 8'h3C;
    tick();
    sif.wr_valid = 1'b0;
    checks++; if (!(sif.stream_out_valid === 1'b1 && sif.stream_out_data === 8'hA5)) begin failures++; $display("FAIL lat_beat0 got=%0b/%0h exp=1/a5", sif.stream_out_valid, sif.stream_out_data); end
    tick();
    checks++; if (!(sif.stream_out_valid === 1'b1 && sif.stream_out_data === 8'h3C)) begin failures++; $display("FAIL lat_beat1 got=%0b/%0h exp=1/3c", sif.stream_out_valid, sif.stream_out_data); end
    checks++; if (beat_count !== 16'd1) begin failures++; $display("FAIL lat_cnt1 got=%0d exp=1", beat_count); end
    tick();
    checks++; if (sif.stream_out_valid !== 1'b0) begin failures++; $display("FAIL lat_end_valid got=%0b exp=0", sif.stream_out_valid); end
    checks++; if (beat_count !== 16'd2) begin failures++; $display("FAIL lat_cnt2 got=%0d exp=2", beat_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL lat_busy got=%0b exp=0", busy); end
    checks++; if (sif.stream_out_data !== 8'h3C) begin failures++; $display("FAIL lat_hold got=%0h exp=3c", sif.stream_out_data); end
  endtask

  task automatic test_backpressure();
    stream_byte_t exp_q[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    stream_byte_t got[8];
    int n;
    bit stable = 1'b1;
    sif.stream_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sif.wr_valid = 1'b1;
      sif.wr_data  = exp_q[i];
      tick();
    end
    checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL bp_level got=%0d exp=4", fifo_level); end
    checks++; if (sif.wr_ready !== 1'b0) begin failures++; $display("FAIL bp_wr_ready got=%0b exp=0", sif.wr_ready); end
    sif.wr_data = 8'h66;
    tick();
    sif.wr_valid = 1'b0;
    checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL bp_full_write got=%0d exp=4", fifo_level); end
    for (int c = 0; c < 10; c++) begin
      if (!(sif.stream_out_valid === 1'b1 && sif.stream_out_data === 8'h11)) stable = 1'b0;
      tick();
    end
    checks++; if (stable !== 1'b1) begin failures++; $display("FAIL bp_stable got=%0b exp=1", stable); end
    sif.stream_out_ready = 1'b1;
    collect(12, got, n);
    checks++; if (n !== 5) begin failures++; $display("FAIL bp_count got=%0d exp=5", n); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (got[i] !== exp_q[i]) begin failures++; $display("FAIL bp_order[%0d] got=%0h exp=%0h", i, got[i], exp_q[i]); end
    end
    checks++; if (beat_count !== 16'd7) begin failures++; $display("FAIL bp_beats got=%0d exp=7", beat_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_gap();
    logic [8:0] exp_v = 9'b1_0001_0001; // bit i = expected valid at step i
    stream_byte_t exp_d[3] = '{8'hAA, 8'hBB, 8'hCC};
    sif.stream_out_ready = 1'b0;
    gap_cycles = 4'd3;
    sif.wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sif.wr_data = exp_d[i];
      tick();
    end
    sif.wr_valid = 1'b0;
    sif.stream_out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      checks++; if (sif.stream_out_valid !== exp_v[i]) begin failures++; $display("FAIL gap_valid[%0d] got=%0b exp=%0b", i, sif.stream_out_valid, exp_v[i]); end
      if (exp_v[i] && sif.stream_out_data !== exp_d[i/4]) begin
        failures++; $display("FAIL gap_data[%0d] got=%0h exp=%0h", i, sif.stream_out_data, exp_d[i/4]);
      end
      if (i == 1) gap_cycles = 4'd15;
      if (i == 4) gap_cycles = 4'd3;
      if (i == 8) gap_cycles = 4'd0;
      tick();
    end
    checks++; if (!(sif.stream_out_valid === 1'b0 && busy === 1'b0)) begin failures++; $display("FAIL gap_no_trailing got=%0b/%0b exp=0/0", sif.stream_out_valid, busy); end
  endtask

  task automatic test_push_pop();
    stream_byte_t exp_q[4] = '{8'h03, 8'h04, 8'h05, 8'h06};
    stream_byte_t got[8];
    int n;
    sif.stream_out_ready = 1'b0;
    sif.wr_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      sif.wr_data = 8'(i);
      tick();
    end
    checks++; if (fifo_level !== 3'd2) begin failures++; $display("FAIL pp_pre_level got=%0d exp=2", fifo_level); end
    sif.stream_out_ready = 1'b1;
    sif.wr_data = 8'h04;
    tick();
    checks++; if (fifo_level !== 3'd2) begin failures++; $display("FAIL pp_level got=%0d exp=2", fifo_level); end
    checks++; if (sif.stream_out_data !== 8'h02) begin failures++; $display("FAIL pp_data got=%0h exp=2", sif.stream_out_data); end
    sif.stream_out_ready = 1'b0;
    sif.wr_data = 8'h05;
    tick();
    sif.wr_data = 8'h06;
    tick();
    sif.stream_out_ready = 1'b1;
    sif.wr_data = 8'h07;
    #1;
    checks++; if (sif.wr_ready !== 1'b0) begin failures++; $display("FAIL pp_full_ready got=%0b exp=0", sif.wr_ready); end
    tick();
    sif.wr_valid = 1'b0;
    checks++; if (fifo_level !== 3'd3) begin failures++; $display("FAIL pp_full_pop got=%0d exp=3", fifo_level); end
    collect(10, got, n);
    checks++; if (n !== 4) begin failures++; $display("FAIL pp_count got=%0d exp=4", n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (got[i] !== exp_q[i]) begin failures++; $display("FAIL pp_order[%0d] got=%0h exp=%0h", i, got[i], exp_q[i]); end
    end
  endtask

`ifdef STREAM_SOURCE_PARITY_EN
  task automatic test_parity();
    sif.stream_out_ready = 1'b0;
    sif.wr_valid = 1'b1;
    sif.wr_data  = 8'h07;
    tick();
    sif.wr_valid = 1'b0;
    tick();
    checks++; if (sif.stream_out_parity !== 1'b1) begin failures++; $display("FAIL par_07 got=%0b exp=1", sif.stream_out_parity); end
    sif.stream_out_ready = 1'b1;
    tick();
    sif.stream_out_ready = 1'b0;
    sif.wr_valid = 1'b1;
    sif.wr_data  = 8'h03;
    tick();
    sif.wr_valid = 1'b0;
    tick();
    checks++; if (sif.stream_out_parity !== 1'b0) begin failures++; $display("FAIL par_03 got=%0b exp=0", sif.stream_out_parity); end
    sif.stream_out_ready = 1'b1;
    repeat (2) tick();
  endtask
`endif

  task automatic test_reset_mid_beat();
    sif.stream_out_ready = 1'b0;
    sif.wr_valid = 1'b1;
    sif.wr_data  = 8'h99;
    tick();
    sif.wr_data  = 8'h98;
    tick();
    sif.wr_valid = 1'b0;
    checks++; if (sif.stream_out_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got=%0b exp=1", sif.stream_out_valid); end
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if (sif.stream_out_valid !== 1'b0) begin failures++; $display("FAIL mid_async_valid got=%0b exp=0", sif.stream_out_valid); end
    checks++; if (beat_count !== 16'd0) begin failures++; $display("FAIL mid_beats got=%0d exp=0", beat_count); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL mid_level got=%0d exp=0", fifo_level); end
    checks++; if (sif.stream_out_data !== 8'h00) begin failures++; $display("FAIL mid_data got=%0h exp=0", sif.stream_out_data); end
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    checks++; if (!(sif.stream_out_valid === 1'b0 && fifo_level === 3'd0 && busy === 1'b0)) begin failures++; $display("FAIL mid_after got=%0b/%0d/%0b exp=0/0/0", sif.stream_out_valid, fifo_level, busy); end
  endtask

  task automatic test_wrap();
    int  accepted = 0;
    bit  seen15 = 1'b0;
    sif_w.stream_out_ready = 1'b1;
    sif_w.wr_valid = 1'b1;
    for (int c = 0; c < 100 && accepted < 16; c++) begin
      sif_w.wr_data = 8'(accepted);
      if (sif_w.wr_ready) accepted++;
      if (beat_w == 4'd15) seen15 = 1'b1;
      tick();
    end
    sif_w.wr_valid = 1'b0;
    for (int c = 0; c < 20 && busy_w; c++) begin
      if (beat_w == 4'd15) seen15 = 1'b1;
      tick();
    end
    checks++; if (accepted !== 16) begin failures++; $display("FAIL wrap_accepted got=%0d exp=16", accepted); end
    checks++; if (busy_w !== 1'b0) begin failures++; $display("FAIL wrap_drain got=%0b exp=0", busy_w); end
    checks++; if (seen15 !== 1'b1) begin failures++; $display("FAIL wrap_seen_max got=%0b exp=1", seen15); end
    checks++; if (beat_w !== 4'd0) begin failures++; $display("FAIL wrap_zero got=%0d exp=0", beat_w); end
    sif_w.wr_valid = 1'b1;
    sif_w.wr_data  = 8'hEE;
    tick();
    sif_w.wr_valid = 1'b0;
    for (int c = 0; c < 10 && busy_w; c++) tick();
    checks++; if (beat_w !== 4'd1) begin failures++; $display("FAIL wrap_one got=%0d exp=1", beat_w); end
  endtask

  initial begin
    reset_n              = 1'b0;
    gap_cycles           = 4'd0;
    sif.wr_valid         = 1'b0;
    sif.wr_data          = 8'h00;
    sif.stream_out_ready = 1'b0;
    gap_w                  = 4'd0;
    sif_w.wr_valid         = 1'b0;
    sif_w.wr_data          = 8'h00;
    sif_w.stream_out_ready = 1'b0;

    test_reset();
    test_latency();
    test_backpressure();
    test_gap();
    test_push_pop();
`ifdef STREAM_SOURCE_PARITY_EN
    test_parity();
`endif
    test_reset_mid_beat();
    test_wrap();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sample_stream_source
